// File: rtl/chunk_feed_ctrl.sv
// Chunk feeder: packs a byte stream into zero-padded 16x32 blocks and hands them to a block hasher.
// Define CHUNK_FEED_WDOG_EN to add a watchdog that aborts a message when the hasher stalls.
module chunk_feed_ctrl #(
    parameter int MAX_BYTES = 1024,
    parameter int WDOG_CYC  = 4096
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start_I,
    input  logic [31:0]       Byte_num_I,
    input  logic [31:0]       Word_I,
    input  logic              Word_vld_I,
    output logic              Word_rdy_O,
    output logic [15:0][31:0] Msg_O,
    output logic              Update_O,
    output logic [31:0]       Byte_num_O,
    input  logic [9:0]        Hasher_addr_I,
    input  logic              Hasher_vld_I,
    output logic              Busy_O,
    output logic              Done_O,
    output logic              Err_O
);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, DRAIN} state_t;

    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

    state_t             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [31:0]        remaining_q, remaining_d;
    logic [3:0]         fill_idx_q, fill_idx_d;
    logic [15:0][31:0]  fill_buf_q, fill_buf_d;
    logic [15:0][31:0]  msg_q, msg_d;
    logic               update_q, update_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               word_rdy_q, word_rdy_d;
    logic               busy_q, busy_d;
    logic               flag_q, flag_d;
    logic [9:0]         addr_prev_q;
    logic               vld_prev_q;

`ifdef CHUNK_FEED_WDOG_EN
    localparam logic [31:0] WDOG_LIM = 32'(WDOG_CYC - 1);
    logic [31:0]        wdog_q, wdog_d;
`endif

    logic               vld_rise;
    logic               hasher_evt;
    logic               handshake;
    logic               issue;
    logic [31:0]        masked_word;
    logic [31:0]        take;

    // Any address movement or a fresh valid from the hasher means it can take another block.
    assign vld_rise   = Hasher_vld_I & ~vld_prev_q;
    assign hasher_evt = (Hasher_addr_I != addr_prev_q) | vld_rise;
    assign handshake  = Word_vld_I & word_rdy_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        fill_idx_d  = fill_idx_q;
        fill_buf_d  = fill_buf_q;
        msg_d       = msg_q;
        update_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        word_rdy_d  = word_rdy_q;
        flag_d      = flag_q | hasher_evt;
        issue       = 1'b0;

        masked_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (remaining_q > 32'(b)) begin
                masked_word[8*b +: 8] = Word_I[8*b +: 8];
            end
        end
        take = (remaining_q < 32'd4) ? remaining_q : 32'd4;

        case (state_q)
            IDLE: begin
                if (Start_I) begin
                    if (Byte_num_I > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        len_d       = Byte_num_I;
                        remaining_d = Byte_num_I;
                        err_d       = 1'b0;
                        flag_d      = 1'b1;
                        fill_idx_d  = '0;
                        fill_buf_d  = '0;
                        // An empty message still hashes one all-zero block.
                        if (Byte_num_I == 32'd0) begin
                            state_d = ISSUE;
                        end else begin
                            state_d    = FILL;
                            word_rdy_d = 1'b1;
                        end
                    end
                end
            end
            FILL: begin
                if (handshake) begin
                    fill_buf_d[fill_idx_q] = masked_word;
                    fill_idx_d             = fill_idx_q + 4'd1;
                    remaining_d            = remaining_q - take;
                    if (fill_idx_q == 4'd15 || remaining_q <= 32'd4) begin
                        state_d    = ISSUE;
                        word_rdy_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (flag_q) begin
                    issue      = 1'b1;
                    msg_d      = fill_buf_q;
                    update_d   = 1'b1;
                    flag_d     = hasher_evt;
                    fill_buf_d = '0;
                    fill_idx_d = '0;
                    if (remaining_q != 32'd0) begin
                        state_d    = FILL;
                        word_rdy_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                word_rdy_d = 1'b0;
            end
        endcase

`ifdef CHUNK_FEED_WDOG_EN
        wdog_d = '0;
        if ((state_q == ISSUE || state_q == DRAIN) && !issue && !(state_q == DRAIN && vld_rise)) begin
            if (hasher_evt || Hasher_vld_I) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_LIM) begin
                err_d      = 1'b1;
                state_d    = IDLE;
                word_rdy_d = 1'b0;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            remaining_q <= '0;
            fill_idx_q  <= '0;
            fill_buf_q  <= '0;
            msg_q       <= '0;
            update_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            word_rdy_q  <= 1'b0;
            busy_q      <= 1'b0;
            flag_q      <= 1'b0;
            addr_prev_q <= '0;
            vld_prev_q  <= 1'b0;
`ifdef CHUNK_FEED_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            fill_idx_q  <= fill_idx_d;
            fill_buf_q  <= fill_buf_d;
            msg_q       <= msg_d;
            update_q    <= update_d;
            done_q      <= done_d;
            err_q       <= err_d;
            word_rdy_q  <= word_rdy_d;
            busy_q      <= busy_d;
            flag_q      <= flag_d;
            addr_prev_q <= Hasher_addr_I;
            vld_prev_q  <= Hasher_vld_I;
`ifdef CHUNK_FEED_WDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign Word_rdy_O = word_rdy_q;
    assign Msg_O      = msg_q;
    assign Update_O   = update_q;
    assign Byte_num_O = len_q;
    assign Busy_O     = busy_q;
    assign Done_O     = done_q;
    assign Err_O      = err_q;

endmodule
